// File: rtl/flit_src_vc_sched_pkg.sv
// Shared types and elaboration helpers for the flit source VC scheduler.
package flit_src_vc_sched_pkg;

  typedef enum logic {
    VC_IDLE,
    VC_BUSY
  } vc_state_e;

  // Ceiling log2: bits needed to index 'value' distinct items.
  function automatic int clogb(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/flit_src_vc_sched_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer;
// on update the pointer moves to one past the granted port.
module c_arbiter
  import flit_src_vc_sched_pkg::*;
#(
  parameter int num_ports = 8,
  localparam int idx_width = clogb(num_ports)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 update,
  input  logic [num_ports-1:0] req,
  output logic [num_ports-1:0] gnt
);

  logic [idx_width-1:0] ptr_q;
  logic [idx_width-1:0] ptr_d;
  logic [idx_width-1:0] sel;
  logic                 found;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < num_ports; i++) begin
      sel = idx_width'((32'(ptr_q) + i) % num_ports);
      if (!found && req[sel]) begin
        gnt[sel] = 1'b1;
        ptr_d    = (sel == idx_width'(num_ports - 1)) ? '0 : sel + 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       ptr_q <= '0;
    else if (update) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/flit_src_vc_sched.sv
// Injection-side VC scheduler: per-VC credit tracking, round-robin VC selection
// and head/body/tail sequencing with flit-level interleaving across VCs.
module flit_src_vc_sched
  import flit_src_vc_sched_pkg::*;
#(
  parameter int num_vcs           = 8,
  parameter int buffer_size       = 64,
  parameter int max_packet_length = 5,
  localparam int vc_idx_width = clogb(num_vcs),
  localparam int len_width    = clogb(max_packet_length + 1),
  localparam int credits_max  = buffer_size / num_vcs,
  localparam int cnt_width    = clogb(credits_max + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [num_vcs-1:0]             pkt_req_ivc,
  input  logic [num_vcs*len_width-1:0]   pkt_len_ivc,
  output logic [num_vcs-1:0]             pkt_ack_ivc,
  input  logic [vc_idx_width:0]          flow_ctrl,
  output logic                           flit_valid,
  output logic                           flit_head,
  output logic                           flit_tail,
  output logic [vc_idx_width-1:0]        flit_vc,
  output logic [num_vcs*cnt_width-1:0]   credit_ivc,
  output logic                           error
);

  localparam logic [cnt_width-1:0] cnt_max = cnt_width'(credits_max);
  localparam logic [len_width-1:0] len_max = len_width'(max_packet_length);
  localparam logic [len_width-1:0] len_one = len_width'(1);

  logic                    fc_valid;
  logic [vc_idx_width-1:0] fc_vc;
  logic                    fc_bad;

  logic [num_vcs-1:0]   eligible;
  logic [num_vcs-1:0]   arb_gnt;
  logic [num_vcs-1:0]   grant;
  logic [num_vcs-1:0]   active;
  logic [num_vcs-1:0]   len_bad;
  logic [num_vcs-1:0]   credit_ovf;
  logic [len_width-1:0] len_eff   [num_vcs];
  logic [len_width-1:0] remaining [num_vcs];

  logic                    grant_any;
  logic [vc_idx_width-1:0] gnt_idx;
  logic                    head_c;
  logic                    tail_c;

  assign fc_valid = flow_ctrl[vc_idx_width];
  assign fc_vc    = flow_ctrl[vc_idx_width-1:0];

  // Out-of-range VC indices only exist when num_vcs is not a power of two.
  if ((1 << vc_idx_width) > num_vcs) begin : g_vc_range
    assign fc_bad = fc_valid & (int'(fc_vc) >= num_vcs);
  end else begin : g_vc_full
    assign fc_bad = 1'b0;
  end

  c_arbiter #(
    .num_ports(num_vcs)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .update (grant_any),
    .req    (eligible),
    .gnt    (arb_gnt)
  );

  assign grant       = arb_gnt & {num_vcs{enable & ~reset}};
  assign grant_any   = |grant;
  assign pkt_ack_ivc = grant & ~active;

  for (genvar v = 0; v < num_vcs; v++) begin : g_vc
    logic [len_width-1:0] len_raw;
    logic [len_width-1:0] rem_q;
    logic [len_width-1:0] rem_d;
    logic [cnt_width-1:0] cred_q;
    vc_state_e            state_q;
    vc_state_e            state_d;
    logic                 inc;

    assign len_raw    = pkt_len_ivc[v*len_width +: len_width];
    assign len_bad[v] = (len_raw == '0) || (len_raw > len_max);
    assign len_eff[v] = len_bad[v] ? len_one : len_raw;

    always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      if (grant[v]) begin
        unique case (state_q)
          VC_IDLE: begin
            if (len_eff[v] != len_one) begin
              state_d = VC_BUSY;
              rem_d   = len_eff[v] - len_one;
            end
          end
          VC_BUSY: begin
            rem_d = rem_q - len_one;
            if (rem_q == len_one) state_d = VC_IDLE;
          end
          default: state_d = VC_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= VC_IDLE;
        rem_q   <= '0;
      end else begin
        state_q <= state_d;
        rem_q   <= rem_d;
      end
    end

    assign active[v]    = (state_q == VC_BUSY);
    assign remaining[v] = rem_q;

    // A return and a grant on the same VC cancel; a return at full credit saturates.
    assign inc           = fc_valid & ~fc_bad & (fc_vc == vc_idx_width'(v));
    assign credit_ovf[v] = inc & ~grant[v] & (cred_q == cnt_max);

    always_ff @(posedge clk or posedge reset) begin
      if (reset)                                        cred_q <= cnt_max;
      else if (inc & ~grant[v] & (cred_q != cnt_max))   cred_q <= cred_q + 1'b1;
      else if (grant[v] & ~inc)                         cred_q <= cred_q - 1'b1;
    end

    assign eligible[v] = (active[v] | pkt_req_ivc[v]) & (cred_q != '0);
    assign credit_ivc[v*cnt_width +: cnt_width] = cred_q;
  end

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < num_vcs; i++) begin
      if (grant[i]) gnt_idx = vc_idx_width'(i);
    end
  end

  assign head_c = ~active[gnt_idx];
  assign tail_c = head_c ? (len_eff[gnt_idx] == len_one) : (remaining[gnt_idx] == len_one);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flit_valid <= 1'b0;
      flit_head  <= 1'b0;
      flit_tail  <= 1'b0;
      flit_vc    <= '0;
      error      <= 1'b0;
    end else begin
      flit_valid <= grant_any;
      flit_head  <= grant_any & head_c;
      flit_tail  <= grant_any & tail_c;
      flit_vc    <= gnt_idx;
      error      <= error | fc_bad | (|credit_ovf) | (|(pkt_ack_ivc & len_bad));
    end
  end

endmodule

// File: tb/tb_flit_src_vc_sched.sv
// Bench for flit_src_vc_sched: directed scenarios plus random traffic against
// a per-VC packet/credit reference model.
module tb_flit_src_vc_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  pkt_req_ivc;
  logic [23:0] pkt_len_ivc;
  logic [7:0]  pkt_ack_ivc;
  logic [3:0]  flow_ctrl;
  logic        flit_valid;
  logic        flit_head;
  logic        flit_tail;
  logic [2:0]  flit_vc;
  logic [31:0] credit_ivc;
  logic        error;

  flit_src_vc_sched #(
    .num_vcs           (8),
    .buffer_size       (64),
    .max_packet_length (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pkt_req_ivc (pkt_req_ivc),
    .pkt_len_ivc (pkt_len_ivc),
    .pkt_ack_ivc (pkt_ack_ivc),
    .flow_ctrl   (flow_ctrl),
    .flit_valid  (flit_valid),
    .flit_head   (flit_head),
    .flit_tail   (flit_tail),
    .flit_vc     (flit_vc),
    .credit_ivc  (credit_ivc),
    .error       (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: flits left in the current packet (0 = idle), credits, RR pointer.
  int m_left [8];
  int m_cred [8];
  int m_rr;
  bit m_err;

  logic [7:0]  exp_ack, obs_ack;
  logic        exp_valid, exp_head, exp_tail;
  logic [2:0]  exp_vc;
  logic [31:0] exp_credit;
  logic        exp_err;

  task automatic reset_model();
    for (int v = 0; v < 8; v++) begin
      m_left[v] = 0;
      m_cred[v] = 8;
    end
    m_rr  = 0;
    m_err = 0;
  endtask

  task automatic set_len(input int v, input int l);
    logic [31:0] lv;
    lv = l;
    pkt_len_ivc[v*3 +: 3] = lv[2:0];
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    enable      = 1'b0;
    pkt_req_ivc = '0;
    pkt_len_ivc = '0;
    flow_ctrl   = '0;
    reset_model();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Predicts one cycle from the current inputs, samples ack mid-cycle, then
  // returns 1 time unit after the clock edge.
  task automatic tick();
    int g, v, L, c;
    g = -1;
    exp_ack = '0; exp_valid = 0; exp_head = 0; exp_tail = 0; exp_vc = '0;
    if (enable) begin
      for (int k = 0; k < 8; k++) begin
        v = (m_rr + k) % 8;
        if (g < 0 && (m_left[v] > 0 || pkt_req_ivc[v]) && m_cred[v] > 0) g = v;
      end
    end
    if (g >= 0) begin
      exp_valid = 1;
      exp_vc    = 3'(g);
      if (m_left[g] == 0) begin
        exp_head   = 1;
        exp_ack[g] = 1'b1;
        L = int'(pkt_len_ivc[g*3 +: 3]);
        if (L < 1 || L > 5) begin
          m_err = 1;
          L = 1;
        end
        m_left[g] = L;
      end
      exp_tail = (m_left[g] == 1);
      m_left[g]--;
      m_rr = (g + 1) % 8;
    end
    c = int'(flow_ctrl[2:0]);
    if (flow_ctrl[3] && c != g) begin
      if (m_cred[c] == 8) m_err = 1;
      else m_cred[c]++;
    end
    if (g >= 0 && !(flow_ctrl[3] && c == g)) m_cred[g]--;
    for (int i = 0; i < 8; i++) exp_credit[i*4 +: 4] = 4'(m_cred[i]);
    exp_err = m_err;
    @(negedge clk);
    obs_ack = pkt_ack_ivc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (credit_ivc !== 32'h8888_8888) begin
      errors++; $display("FAIL reset_credit: got %h expected %h", credit_ivc, 32'h8888_8888);
    end
    checks++;
    if ({flit_valid, flit_head, flit_tail, flit_vc, pkt_ack_ivc} !== '0) begin
      errors++; $display("FAIL reset_outputs: got v%b h%b t%b vc%0d ack%h expected all 0",
                         flit_valid, flit_head, flit_tail, flit_vc, pkt_ack_ivc);
    end
    checks++;
    if (error !== 1'b0) begin
      errors++; $display("FAIL reset_error: got %b expected 0", error);
    end
  endtask

  task automatic test_single();
    logic [1:0] ht [3] = '{2'b10, 2'b00, 2'b01};
    int acks = 0;
    do_reset();
    enable = 1'b1;
    pkt_req_ivc = 8'h04;
    set_len(2, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({obs_ack, flit_valid, flit_head, flit_tail, flit_vc} !== {exp_ack, exp_valid, exp_head, exp_tail, exp_vc}) begin
        errors++; $display("FAIL single_model: got ack%h v%b h%b t%b vc%0d expected ack%h v%b h%b t%b vc%0d",
                           obs_ack, flit_valid, flit_head, flit_tail, flit_vc, exp_ack, exp_valid, exp_head, exp_tail, exp_vc);
      end
      checks++;
      if ({flit_valid, flit_head, flit_tail, flit_vc} !== {1'b1, ht[i], 3'd2}) begin
        errors++; $display("FAIL single_flit%0d: got v%b h%b t%b vc%0d expected v1 ht%b vc2",
                           i, flit_valid, flit_head, flit_tail, flit_vc, ht[i]);
      end
      if (obs_ack[2]) begin
        acks++;
        pkt_req_ivc[2] = 1'b0;
      end
    end
    checks++;
    if (acks != 1) begin
      errors++; $display("FAIL single_ack_count: got %0d expected 1", acks);
    end
    checks++;
    if (credit_ivc[11:8] !== 4'd5) begin
      errors++; $display("FAIL single_credit: got %0d expected 5", credit_ivc[11:8]);
    end
  endtask

  task automatic test_interleave();
    logic [2:0] vcs [4] = '{3'd0, 3'd1, 3'd0, 3'd1};
    logic       hd  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       tl  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    enable = 1'b1;
    pkt_req_ivc = 8'h03;
    set_len(0, 2);
    set_len(1, 2);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({obs_ack, flit_valid, flit_head, flit_tail, flit_vc} !== {exp_ack, exp_valid, exp_head, exp_tail, exp_vc}) begin
        errors++; $display("FAIL interleave_model: got ack%h v%b h%b t%b vc%0d expected ack%h v%b h%b t%b vc%0d",
                           obs_ack, flit_valid, flit_head, flit_tail, flit_vc, exp_ack, exp_valid, exp_head, exp_tail, exp_vc);
      end
      checks++;
      if ({flit_valid, flit_head, flit_tail, flit_vc} !== {1'b1, hd[i], tl[i], vcs[i]}) begin
        errors++; $display("FAIL interleave_flit%0d: got v%b h%b t%b vc%0d expected v1 h%b t%b vc%0d",
                           i, flit_valid, flit_head, flit_tail, flit_vc, hd[i], tl[i], vcs[i]);
      end
      pkt_req_ivc = pkt_req_ivc & ~obs_ack;
    end
  endtask

  task automatic test_credit_stall();
    int n1 = 0, n2 = 0, n3 = 0;
    do_reset();
    enable = 1'b1;
    pkt_req_ivc = 8'h08;
    set_len(3, 5);
    for (int i = 0; i < 20; i++) begin
      if (i == 6) pkt_req_ivc[3] = 1'b1;
      flow_ctrl = (i == 14) ? 4'b1011 : 4'b0000;
      tick();
      checks++;
      if ({obs_ack, flit_valid, flit_head, flit_tail, flit_vc} !== {exp_ack, exp_valid, exp_head, exp_tail, exp_vc}) begin
        errors++; $display("FAIL stall_model: got ack%h v%b h%b t%b vc%0d expected ack%h v%b h%b t%b vc%0d",
                           obs_ack, flit_valid, flit_head, flit_tail, flit_vc, exp_ack, exp_valid, exp_head, exp_tail, exp_vc);
      end
      checks++;
      if (credit_ivc !== exp_credit) begin
        errors++; $display("FAIL stall_credit: got %h expected %h", credit_ivc, exp_credit);
      end
      if (obs_ack[3]) pkt_req_ivc[3] = 1'b0;
      if (flit_valid) begin
        if (i < 6) n1++;
        else if (i < 14) n2++;
        else n3++;
      end
      if (i == 13) begin
        checks++;
        if (credit_ivc[15:12] !== 4'd0) begin
          errors++; $display("FAIL stall_zero_credit: got %0d expected 0", credit_ivc[15:12]);
        end
      end
    end
    flow_ctrl = '0;
    checks++;
    if ({n1, n2, n3} !== {32'd5, 32'd3, 32'd1}) begin
      errors++; $display("FAIL stall_flit_counts: got %0d/%0d/%0d expected 5/3/1", n1, n2, n3);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    enable = 1'b1;
    pkt_req_ivc = 8'h02;
    set_len(1, 1);
    flow_ctrl = 4'b1001;
    tick();
    checks++;
    if ({flit_valid, flit_head, flit_tail, flit_vc, credit_ivc[7:4], error} !== {3'b111, 3'd1, 4'd8, 1'b0}) begin
      errors++; $display("FAIL same_cycle_grant: got v%b h%b t%b vc%0d cr%0d err%b expected v1 h1 t1 vc1 cr8 err0",
                         flit_valid, flit_head, flit_tail, flit_vc, credit_ivc[7:4], error);
    end
    pkt_req_ivc = '0;
    tick();
    flow_ctrl = '0;
    checks++;
    if ({error, credit_ivc[7:4]} !== {exp_err, exp_credit[7:4]} || {error, credit_ivc[7:4]} !== {1'b1, 4'd8}) begin
      errors++; $display("FAIL same_cycle_overflow: got err%b cr%0d expected err1 cr8", error, credit_ivc[7:4]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1;
    pkt_req_ivc = 8'h10;
    set_len(4, 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({obs_ack, flit_valid, flit_head, flit_tail, flit_vc} !== {exp_ack, exp_valid, exp_head, exp_tail, exp_vc}) begin
        errors++; $display("FAIL midreset_model: got ack%h v%b h%b t%b vc%0d expected ack%h v%b h%b t%b vc%0d",
                           obs_ack, flit_valid, flit_head, flit_tail, flit_vc, exp_ack, exp_valid, exp_head, exp_tail, exp_vc);
      end
      if (obs_ack[4]) pkt_req_ivc[4] = 1'b0;
    end
    pkt_req_ivc[5] = 1'b1;
    set_len(5, 2);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({flit_valid, flit_head, flit_tail, flit_vc, pkt_ack_ivc, error} !== '0 || credit_ivc !== 32'h8888_8888) begin
      errors++; $display("FAIL midreset_outputs: got v%b h%b t%b vc%0d ack%h err%b cr%h expected zeros and cr 88888888",
                         flit_valid, flit_head, flit_tail, flit_vc, pkt_ack_ivc, error, credit_ivc);
    end
    reset_model();
    @(posedge clk);
    #1;
    reset = 1'b0;
    pkt_req_ivc = 8'h10;
    set_len(4, 2);
    tick();
    checks++;
    if ({obs_ack, flit_valid, flit_head, flit_tail, flit_vc} !== {exp_ack, exp_valid, exp_head, exp_tail, exp_vc}
        || {flit_valid, flit_head, flit_vc} !== {2'b11, 3'd4}) begin
      errors++; $display("FAIL midreset_restart: got ack%h v%b h%b t%b vc%0d expected ack10 v1 h1 t0 vc4",
                         obs_ack, flit_valid, flit_head, flit_tail, flit_vc);
    end
  endtask

  task automatic test_random();
    int c;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      enable = ($urandom % 5) != 0;
      for (int v = 0; v < 8; v++) begin
        if (!pkt_req_ivc[v] && ($urandom % 3) == 0) begin
          pkt_req_ivc[v] = 1'b1;
          set_len(v, (($urandom % 25) == 0) ? int'($urandom % 8) : 1 + int'($urandom % 5));
        end
      end
      flow_ctrl = '0;
      if (($urandom % 2) == 0) begin
        c = int'($urandom % 8);
        if (m_cred[c] < 8 || ($urandom % 40) == 0) flow_ctrl = {1'b1, 3'(c)};
      end
      tick();
      checks++;
      if ({obs_ack, flit_valid, flit_head, flit_tail, flit_vc} !== {exp_ack, exp_valid, exp_head, exp_tail, exp_vc}) begin
        errors++; $display("FAIL random_flit cyc%0d: got ack%h v%b h%b t%b vc%0d expected ack%h v%b h%b t%b vc%0d", cyc,
                           obs_ack, flit_valid, flit_head, flit_tail, flit_vc, exp_ack, exp_valid, exp_head, exp_tail, exp_vc);
      end
      checks++;
      if (credit_ivc !== exp_credit || error !== exp_err) begin
        errors++; $display("FAIL random_credit cyc%0d: got cr%h err%b expected cr%h err%b",
                           cyc, credit_ivc, error, exp_credit, exp_err);
      end
      pkt_req_ivc = pkt_req_ivc & ~obs_ack;
    end
    flow_ctrl = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_interleave();
    test_credit_stall();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
